// File: rtl/register_file.sv
// 32 x 32 MIPS register file: two combinational read ports, one write port, $0 tied to zero,
// plus a ready/valid dump engine. Define REGISTER_FILE_WRITE_BYPASS_EN for same-cycle write forwarding.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] register_file_read_address_1,
  input  logic [ADDR_WIDTH-1:0] register_file_read_address_2,
  output logic [DATA_WIDTH-1:0] register_file_read_value_1,
  output logic [DATA_WIDTH-1:0] register_file_read_value_2,
  input  logic [ADDR_WIDTH-1:0] register_file_write_address,
  input  logic [DATA_WIDTH-1:0] register_file_write_value,
  input  logic                  register_file_write_enable,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [4:0]            dump_index,
  output logic [DATA_WIDTH-1:0] dump_value,
  output logic                  dump_done,
  output logic                  dump_busy
);

  localparam int         REG_INDEX_WIDTH = $clog2(NUM_REGS);
  localparam logic [4:0] LAST_INDEX      = 5'(NUM_REGS - 1);
  localparam int         NUM_PORTS       = 3;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } dump_state_t;

  dump_state_t dump_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];

  // Register 0 and anything at or beyond NUM_REGS are not backed by storage.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr != '0) && (int'(addr) < NUM_REGS);
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the whole array is reset because software expects every register
      // to read 0 after reset; this rules out mapping the array onto a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (register_file_write_enable && in_range(register_file_write_address)) begin
      // NOTE: sequential state is always updated with <= so every flop samples
      // pre-edge values regardless of block ordering.
      regs[register_file_write_address[REG_INDEX_WIDTH-1:0]] <= register_file_write_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: two processor ports plus the dump port share one lookup.
  // ---------------------------------------------------------------------------
  assign port_addr[0] = register_file_read_address_1;
  assign port_addr[1] = register_file_read_address_2;
  assign port_addr[2] = ADDR_WIDTH'(dump_index);

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      // NOTE: defaulting every output first keeps this block free of latches
      // on the out-of-range paths.
      port_data[p] = '0;
      if (in_range(port_addr[p])) begin
        port_data[p] = regs[port_addr[p][REG_INDEX_WIDTH-1:0]];
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
        if (register_file_write_enable && (register_file_write_address == port_addr[p])) begin
          port_data[p] = register_file_write_value;
        end
`endif
      end
    end
  end

  assign register_file_read_value_1 = port_data[0];
  assign register_file_read_value_2 = port_data[1];
  assign dump_value                 = port_data[2];

  // ---------------------------------------------------------------------------
  // Dump engine: one beat per register, held under backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dump_state <= IDLE;
      dump_valid <= 1'b0;
      dump_index <= '0;
      dump_done  <= 1'b0;
      dump_busy  <= 1'b0;
    end else begin
      case (dump_state)
        IDLE: begin
          dump_done <= 1'b0;
          if (dump_start) begin
            dump_state <= STREAM;
            dump_valid <= 1'b1;
            dump_index <= '0;
            dump_busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (dump_ready) begin
            if (dump_index == LAST_INDEX) begin
              dump_state <= DONE;
              dump_valid <= 1'b0;
              dump_index <= '0;
              dump_done  <= 1'b1;
            end else begin
              dump_index <= dump_index + 5'd1;
            end
          end
        end
        DONE: begin
          // A start request seen here is dropped; it must be re-issued in IDLE.
          dump_state <= IDLE;
          dump_done  <= 1'b0;
          dump_busy  <= 1'b0;
        end
        default: begin
          dump_state <= IDLE;
          dump_valid <= 1'b0;
          dump_index <= '0;
          dump_done  <= 1'b0;
          dump_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an array-based model.
module tb_register_file;

  localparam int NREG      = 32;
  localparam int PH_IDLE   = 0;
  localparam int PH_STREAM = 1;
  localparam int PH_DONE   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  rd_addr_1 = '0;
  logic [5:0]  rd_addr_2 = '0;
  logic [31:0] rd_value_1;
  logic [31:0] rd_value_2;
  logic [5:0]  wr_addr = '0;
  logic [31:0] wr_value = '0;
  logic        wr_en = 1'b0;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b0;
  logic        dump_valid;
  logic [4:0]  dump_index;
  logic [31:0] dump_value;
  logic        dump_done;
  logic        dump_busy;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .clock                        (clock),
    .reset                        (reset),
    .register_file_read_address_1 (rd_addr_1),
    .register_file_read_address_2 (rd_addr_2),
    .register_file_read_value_1   (rd_value_1),
    .register_file_read_value_2   (rd_value_2),
    .register_file_write_address  (wr_addr),
    .register_file_write_value    (wr_value),
    .register_file_write_enable   (wr_en),
    .dump_start                   (dump_start),
    .dump_ready                   (dump_ready),
    .dump_valid                   (dump_valid),
    .dump_index                   (dump_index),
    .dump_value                   (dump_value),
    .dump_done                    (dump_done),
    .dump_busy                    (dump_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain array plus a count of accepted dump beats.
  // ---------------------------------------------------------------------------
  logic [31:0] model [NREG] = '{default: '0};
  int          phase = PH_IDLE;
  int          beats = 0;

  function automatic logic [31:0] expected_read(input logic [5:0] a);
    if (a == 6'd0 || int'(a) >= NREG) return 32'h0;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_value;
`endif
    return model[a[4:0]];
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) model[i] <= '0;
      phase <= PH_IDLE;
      beats <= 0;
    end else begin
      if (phase == PH_IDLE && dump_start) begin
        phase <= PH_STREAM;
        beats <= 0;
      end else if (phase == PH_STREAM && dump_ready) begin
        if (beats == NREG - 1) phase <= PH_DONE;
        else beats <= beats + 1;
      end else if (phase == PH_DONE) begin
        phase <= PH_IDLE;
      end
      if (wr_en && wr_addr != 6'd0 && int'(wr_addr) < NREG) model[wr_addr[4:0]] <= wr_value;
    end
  end

  // Per-cycle comparison against the model, mid-low-phase.
  always @(negedge clock) begin
    #2;
    check("read_1", rd_value_1, expected_read(rd_addr_1));
    check("read_2", rd_value_2, expected_read(rd_addr_2));
    check("dump_busy", dump_busy, 32'(phase != PH_IDLE));
    check("dump_valid", dump_valid, 32'(phase == PH_STREAM));
    check("dump_done", dump_done, 32'(phase == PH_DONE));
    if (phase == PH_STREAM) begin
      check("dump_index", 32'(dump_index), 32'(beats));
      check("dump_value", dump_value, expected_read(6'(beats)));
    end
    if (phase == PH_IDLE) check("dump_index_idle", 32'(dump_index), 32'h0);
  end

  task automatic write_reg(input logic [5:0] a, input logic [31:0] v);
    @(negedge clock);
    wr_en    = 1'b1;
    wr_addr  = a;
    wr_value = v;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  initial begin
    int   acc_cnt;
    int   bad_seq;
    int   done_cnt;
    logic [31:0] first_val;
    logic [31:0] last_val;
    logic finished;
    logic stalled;

    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    #3;
    check("reset_read_1", rd_value_1, 32'h0);
    check("reset_busy", 32'(dump_busy), 32'h0);
    check("reset_valid", 32'(dump_valid), 32'h0);
    check("reset_index", 32'(dump_index), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Basic write/read and r0.
    write_reg(6'd3, 32'hDEAD_BEEF);
    write_reg(6'd31, 32'h1);
    rd_addr_1 = 6'd3;
    rd_addr_2 = 6'd31;
    #3;
    check("lit_r3", rd_value_1, 32'hDEAD_BEEF);
    check("lit_r31", rd_value_2, 32'h1);
    write_reg(6'd0, 32'hFFFF_FFFF);
    rd_addr_1 = 6'd0;
    #3;
    check("lit_r0", rd_value_1, 32'h0);

    // Out-of-range write is dropped.
    write_reg(6'd5, 32'h5555);
    write_reg(6'h25, 32'hAAAA);
    rd_addr_1 = 6'd5;
    rd_addr_2 = 6'h25;
    #3;
    check("lit_oor_r5", rd_value_1, 32'h5555);
    check("lit_oor_read", rd_value_2, 32'h0);

    // Asynchronous reset mid-cycle.
    write_reg(6'd5, 32'h1234);
    rd_addr_1 = 6'd5;
    rd_addr_2 = 6'd31;
    #3;
    check("lit_r5_pre_reset", rd_value_1, 32'h1234);
    reset = 1'b1;
    #1;
    check("lit_r5_async_reset", rd_value_1, 32'h0);
    check("lit_r31_async_reset", rd_value_2, 32'h0);
    check("lit_busy_async_reset", 32'(dump_busy), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Same-cycle write and read of r7.
    write_reg(6'd7, 32'h10);
    wr_en     = 1'b1;
    wr_addr   = 6'd7;
    wr_value  = 32'h20;
    rd_addr_1 = 6'd7;
    rd_addr_2 = 6'd0;
    #3;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    check("lit_r7_same_cycle", rd_value_1, 32'h20);
`else
    check("lit_r7_same_cycle", rd_value_1, 32'h10);
`endif
    @(negedge clock);
    wr_addr  = 6'd0;
    wr_value = 32'hFFFF;
    #3;
    check("lit_r7_next_cycle", rd_value_1, 32'h20);
    check("lit_r0_no_bypass", rd_value_2, 32'h0);
    @(negedge clock);
    wr_en = 1'b0;

    // Dump with alternating backpressure.
    for (int n = 1; n < NREG; n++) write_reg(6'(n), 32'(n * 32'h11));
    dump_start = 1'b1;
    dump_ready = 1'b0;
    @(negedge clock);
    dump_start = 1'b0;
    acc_cnt = 0; bad_seq = 0; done_cnt = 0; finished = 1'b0;
    first_val = 32'hFFFF_FFFF; last_val = '0;
    for (int i = 0; i < 200 && !finished; i++) begin
      dump_ready = (i % 2 == 0);
      dump_start = (i == 10);
      #3;
      if (dump_valid && dump_ready) begin
        if (dump_index != 5'(acc_cnt)) bad_seq++;
        if (dump_value != 32'(acc_cnt * 32'h11)) bad_seq++;
        if (acc_cnt == 0) first_val = dump_value;
        last_val = dump_value;
        acc_cnt++;
      end
      if (dump_done) done_cnt++;
      if (done_cnt > 0 && !dump_done && !dump_busy) finished = 1'b1;
      @(negedge clock);
    end
    dump_start = 1'b0;
    dump_ready = 1'b0;
    check("lit_dump_finished", 32'(finished), 32'h1);
    check("lit_dump_beats", 32'(acc_cnt), 32'd32);
    check("lit_dump_sequence_errors", 32'(bad_seq), 32'h0);
    check("lit_dump_done_pulses", 32'(done_cnt), 32'h1);
    check("lit_dump_first", first_val, 32'h0);
    check("lit_dump_last", last_val, 32'h20F);

    // Write during a stall at index 4, then reset mid-dump.
    dump_start = 1'b1;
    @(negedge clock);
    dump_start = 1'b0;
    stalled = 1'b0;
    for (int i = 0; i < 100 && !stalled; i++) begin
      if (dump_valid && dump_index == 5'd4) begin
        dump_ready = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 6'd4;
        wr_value   = 32'h99;
        stalled    = 1'b1;
      end else begin
        dump_ready = 1'b1;
        @(negedge clock);
      end
    end
    check("lit_stall_reached", 32'(stalled), 32'h1);
    #3;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    check("lit_stall_value_before", dump_value, 32'h99);
`else
    check("lit_stall_value_before", dump_value, 32'h44);
`endif
    @(negedge clock);
    wr_en = 1'b0;
    #3;
    check("lit_stall_value_after", dump_value, 32'h99);
    check("lit_stall_index", 32'(dump_index), 32'h4);
    reset = 1'b1;
    #1;
    check("lit_reset_mid_dump_valid", 32'(dump_valid), 32'h0);
    check("lit_reset_mid_dump_busy", 32'(dump_busy), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      reset    = ($urandom_range(0, 499) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      wr_value = $urandom;
      rd_addr_1 = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 39));
      rd_addr_2 = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      dump_start = ($urandom_range(0, 29) == 0);
      dump_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    reset      = 1'b0;
    wr_en      = 1'b0;
    dump_start = 1'b0;
    @(negedge clock);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit MIPS general-purpose register file.
- Serves as the responder to the processor's register-file interface: two combinational read ports and one synchronous write port, with $0 hardwired to zero.
- Includes a sequential dump engine that streams all registers out for bench checking and debug.

Parameters:
DATA_WIDTH, 32, width of each register and of the read, write and dump data paths
ADDR_WIDTH, 6, width of the read and write address ports (matches processor ports)
NUM_REGS, 32, number of implemented registers; valid addresses are 0..NUM_REGS-1

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
register_file_read_address_1  input  6  read port 1 address
register_file_read_address_2  input  6  read port 2 address
register_file_read_value_1  output  32  read port 1 data (combinational)
register_file_read_value_2  output  32  read port 2 data (combinational)
register_file_write_address  input  6  write address
register_file_write_value  input  32  write data
register_file_write_enable  input  1  write strobe, sampled at posedge
dump_start  input  1  one-cycle request to stream all registers
dump_ready  input  1  consumer can accept the current dump beat
dump_valid  output  1  dump_index/dump_value hold a valid beat
dump_index  output  5  register number of the current beat
dump_value  output  32  contents of register dump_index
dump_done  output  1  one-cycle pulse after the last beat is accepted
dump_busy  output  1  high while the dump engine is not IDLE

Behaviour:
- Reset (asynchronous assert, any time):
  - All registers cleared to 0.
  - Dump FSM goes to IDLE.
  - dump_valid=0, dump_index=0, dump_done=0, dump_busy=0.
  - Read outputs therefore return 0.
- Reads:
  - Purely combinational, zero-cycle latency.
  - Address 0, or any address >= NUM_REGS (including any address with bit 5 set), returns 0.
- Writes:
  - On posedge with write_enable=1 and 0 < address < NUM_REGS, the register takes write_value.
  - Writes to address 0 or out-of-range addresses are discarded.
  - The written value is visible on the read ports the cycle after the edge (no bypass unless the optional feature is enabled).
- Dump FSM states: IDLE, STREAM, DONE.
  - IDLE: dump_start=1 -> STREAM, with dump_index=0 and dump_valid=1 from the next cycle.
  - STREAM:
    - dump_value = current contents of register dump_index, combinational. A write to that register during a stall changes dump_value on the next cycle.
    - dump_valid && dump_ready: if dump_index<NUM_REGS-1, increment dump_index and stay in STREAM; if dump_index==NUM_REGS-1, go to DONE and clear dump_valid.
    - dump_ready=0: hold index and valid (backpressure; no timeout).
  - DONE: dump_done=1 for exactly one cycle, dump_index returns to 0, next state IDLE.
  - dump_start while in STREAM or DONE is ignored.
  - dump_start in the same cycle dump_done is high is ignored; it must be re-asserted in IDLE.
  - dump_busy=1 in STREAM and DONE.
  - Register 0 is dumped as 0.
- Register writes proceed normally during a dump; the dump never blocks the write port.
- Simultaneous write and read of the same address in one cycle: the read returns the old value (unless bypass is enabled).

Optional Feature:
- Macro: REGISTER_FILE_WRITE_BYPASS_EN
- Defined:
  - When write_enable=1, write_address matches a read address, and the address is 1..NUM_REGS-1, that read port returns write_value combinationally in the same cycle.
  - Applies to both read ports and to dump_value.
  - Address 0 is never bypassed.
- Undefined: no bypass; reads return array contents only (the processor covers writeback via its own forwarding).

Test Plan:
- Reset: assert reset mid-run after writing r5=0x1234 -> reads of r5 and r31 return 0 immediately (asynchronous); dump_busy=0.
- Write/read: write r3=0xDEADBEEF, then r31=0x1 -> next cycle read_value_1(r3)=0xDEADBEEF and read_value_2(r31)=0x1; write r0=0xFFFFFFFF -> r0 reads 0.
- Out-of-range: write address 6'h25 value 0xAAAA -> r5 unchanged; read 6'h25 returns 0.
- Same-cycle write/read of r7 (old 0x10, new 0x20):
  - Without the macro, read gives 0x10 that cycle and 0x20 the next.
  - With REGISTER_FILE_WRITE_BYPASS_EN, read gives 0x20 that cycle; r0 is never bypassed.
- Dump with backpressure:
  - Setup: load rN=N*0x11; pulse dump_start; toggle dump_ready 1,0,1,...
  - Expect exactly 32 accepted beats, index 0..31, values N*0x11 (r0=0), index held while ready=0.
  - Then dump_done high for 1 cycle and busy falls; a second dump_start during STREAM has no effect.
- Write during dump stall: stall at index 4, write r4=0x99 -> dump_value becomes 0x99 the next cycle; reset asserted mid-dump returns the FSM to IDLE with dump_valid=0.
